// File: rtl/imem_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | imem_port_arbiter: shares the instruction-ROM read port between IF and LS. |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module imem_port_arbiter #(
  parameter int ADDR_W       = 17,
  parameter int DATA_W       = 32,
  parameter int DEPTH_WORDS  = 32768,
  parameter int ROM_LAT      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              ls_req,
  input  logic [ADDR_W-1:0] ls_addr,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_err,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_inst
);

  localparam int LAT_W = (ROM_LAT < 2) ? 1 : $clog2(ROM_LAT + 1);
  localparam int STV_W = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ERR    = 2'd2
  } state_t;

  state_t             state;
  logic [LAT_W-1:0]   lat_cnt;
  logic [STV_W-1:0]   starve_cnt;
  logic               owner_ls;
  logic [DATA_W-1:0]  if_rdata_q;
  logic [DATA_W-1:0]  ls_rdata_q;
  logic               if_err_q;
  logic               ls_err_q;

  logic               resp_ok;
  logic               resp_err;
  logic               resp;
  logic               can_grant;
  logic               ls_forced;
  logic               any_gnt;
  logic [ADDR_W-1:0]  sel_addr;
  logic [31:0]        sel_word;
  logic               addr_bad;
  logic [DATA_W-1:0]  resp_data;

  // The response cycle doubles as a grant slot so back-to-back accesses lose no cycle.
  assign resp_ok   = (state == ACCESS) && (lat_cnt == LAT_W'(ROM_LAT));
  assign resp_err  = (state == ERR);
  assign resp      = resp_ok || resp_err;
  assign can_grant = reset_n && ((state == IDLE) || resp);
  assign ls_forced = (starve_cnt == STV_W'(STARVE_LIMIT));

  assign if_gnt  = can_grant && if_req && !(ls_req && ls_forced);
  assign ls_gnt  = can_grant && ls_req && (!if_req || ls_forced);
  assign any_gnt = if_gnt || ls_gnt;

  assign sel_addr = ls_gnt ? ls_addr : if_addr;
  assign sel_word = 32'(sel_addr[ADDR_W-1:2]);
  assign addr_bad = (sel_addr[1:0] != 2'b00) || (sel_word >= 32'(DEPTH_WORDS));

  assign if_rvalid = resp && !owner_ls;
  assign ls_rvalid = resp && owner_ls;
  assign resp_data = resp_ok ? rom_inst : '0;

  // Data is only sampled from the ROM in the response cycle; otherwise hold.
  assign if_rdata = if_rvalid ? resp_data : if_rdata_q;
  assign if_err   = if_rvalid ? resp_err  : if_err_q;
  assign ls_rdata = ls_rvalid ? resp_data : ls_rdata_q;
  assign ls_err   = ls_rvalid ? resp_err  : ls_err_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      owner_ls   <= 1'b0;
      rom_en     <= 1'b0;
      rom_addr   <= '0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
      if_err_q   <= 1'b0;
      ls_err_q   <= 1'b0;
    end else begin
      if (if_rvalid) begin
        if_rdata_q <= resp_data;
        if_err_q   <= resp_err;
      end
      if (ls_rvalid) begin
        ls_rdata_q <= resp_data;
        ls_err_q   <= resp_err;
      end

      if (ls_gnt) begin
        starve_cnt <= '0;
      end else if (if_gnt && ls_req && !ls_forced) begin
        starve_cnt <= starve_cnt + STV_W'(1);
      end

      if (any_gnt) begin
        owner_ls <= ls_gnt;
        lat_cnt  <= '0;
        if (addr_bad) begin
          state  <= ERR;
          rom_en <= 1'b0;
        end else begin
          state    <= ACCESS;
          rom_en   <= 1'b1;
          rom_addr <= sel_addr;
        end
      end else if (resp) begin
        state  <= IDLE;
        rom_en <= 1'b0;
      end else if (state == ACCESS) begin
        lat_cnt <= lat_cnt + LAT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire
